imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory the 10-bit CPU fetches from. It accepts a framed byte stream over a valid/ready interface, packs pairs of bytes into 10-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It holds the CPU in reset until a frame's checksum verifies.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `MAX_WORDS`, default 1024: instruction memory depth; the largest legal word count.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts the byte this cycle; transfer occurs when `in_valid && in_ready`
- `imem_we`  out  1  instruction-memory write strobe, one-cycle pulse
- `imem_addr`  out  10  write address
- `imem_wdata`  out  10  write data (instruction word)
- `cpu_hold`  out  1  CPU reset/hold request; drives the CPU's `rst` through the top level
- `load_done`  out  1  last frame loaded and verified
- `load_error`  out  1  last frame rejected

## Operation
Frame format, one byte per transfer:
- `SYNC`, then `LEN_LO`, then `LEN_HI`.
- N = {LEN_HI[2:0], LEN_LO}. LEN_HI[7:3] must be 0.
- Then N word pairs: `LO` = word[7:0]; `HI` = {6'b0, word[9:8]}.
- Then `CHK` = XOR of every byte after `SYNC` up to the last `HI`.

States:
- **IDLE** (after reset): in_ready=1. A `SYNC` byte goes to LEN_L and clears the running XOR. Other bytes are consumed and ignored.
- **LEN_L**: store the byte, fold it into the XOR, go to LEN_H.
- **LEN_H**: fold into the XOR. If N==0, N>MAX_WORDS, or LEN_HI[7:3]!=0, go to ERROR. Otherwise load the word counter with N, set the address to 0, go to DAT_L.
- **DAT_L**: latch the low byte, fold into the XOR, go to DAT_H.
- **DAT_H**: fold into the XOR. If byte[7:2]!=0, go to ERROR. Otherwise latch word[9:8] and go to WRITE.
- **WRITE** (one cycle, in_ready=0): imem_we=1 with the current addr/data. Then increment the address and decrement the counter. If the counter reaches 0, go to CHECK; otherwise go to DAT_L.
- **CHECK**: compare the received byte with the XOR. On a match go to DONE, otherwise go to ERROR.
- **DONE**: cpu_hold=0, load_done=1. A `SYNC` byte sets cpu_hold=1 and load_done=0, then goes to LEN_L (reload). Other bytes are ignored.
- **ERROR**: cpu_hold=1, load_error=1. A `SYNC` byte clears load_error and goes to LEN_L. Other bytes are ignored.

Rules:
- Words already written by a rejected frame stay in memory. No rollback.
- The address never wraps within a frame; N ≤ MAX_WORDS guarantees this.
- No in-frame timeout or resync. A `SYNC` value inside a frame is treated as data.
- In every state except WRITE, in_valid=0 stalls the state machine with no other effect.

## Timing
- All outputs are registered, except `in_ready`, which is decoded from the state register.
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, state IDLE.
- Reset mid-frame returns to IDLE immediately. Memory contents are unspecified.
- Throughput at full-rate `in_valid`: 3 cycles per word (LO, HI, WRITE).
- imem_we is asserted in the cycle after the HI byte is accepted. imem_addr and imem_wdata are valid for that same cycle, and addr/data are held outside the pulse.
- cpu_hold deasserts in the cycle after `CHK` is accepted, coincident with load_done rising.
- Minimum frame of N words: 4 + 3N cycles from `SYNC` acceptance to load_done.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LEN_L, LEN_H, DAT_L, DAT_H, WRITE, CHECK, DONE, ERROR)
  - `SYNC_BYTE` default
  - instruction width 10
  - address width 10
- Single module, no sub-module. The XOR accumulator and word counter are inline registers.

## Test plan
- Basic load: A5, 02, 00, 34, 01, 07, 02, then CHK = 02^00^34^01^07^02 = 0x32. Expect writes addr0=0x134 and addr1=0x207, then cpu_hold 1→0 and load_done=1.
- Bad checksum: same frame with CHK=0x33. Expect both writes, then load_error=1 and cpu_hold stays 1. A following good frame clears load_error and sets load_done.
- Bad high byte: A5, 01, 00, 12, 04. Expect no imem_we and load_error=1 on the cycle after 04.
- Length limits: LEN 0x0000 → error; LEN 0x0401 → error; LEN 0x0400 with 1024 words → last write at addr 0x3FF, then done.
- Backpressure and stall: toggle in_valid randomly during the basic load. Expect identical writes, and in_ready=0 exactly in the WRITE cycles.
- Reset and reload: assert rst after the first word of a 3-word frame. Expect IDLE, cpu_hold=1, outputs at reset values. In DONE, send A5 → cpu_hold=1 and load_done=0 the next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and widths for the instruction-memory boot loader
package imem_loader_pkg;

    localparam int INSTR_W = 10;
    localparam int ADDR_W  = 10;
    localparam int CNT_W   = ADDR_W + 1;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN_L = 4'd1,
        S_LEN_H = 4'd2,
        S_DAT_L = 4'd3,
        S_DAT_H = 4'd4,
        S_WRITE = 4'd5,
        S_CHECK = 4'd6,
        S_DONE  = 4'd7,
        S_ERROR = 4'd8
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write bus and status out
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               load_done;
    logic               load_error;

    // master: stream source / status observer; slave: the loader itself
    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_done, load_error
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_done, load_error
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to 10-bit instruction memory, CPU held until checksum verifies
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MAX_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

    state_t             r_state;
    logic [7:0]         r_xor;
    logic [7:0]         r_len_lo;
    logic [7:0]         r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_we;
    logic               r_cpu_hold;
    logic               r_load_done;
    logic               r_load_error;

    logic               w_in_ready;
    logic               w_fire;
    logic               w_sync;
    logic [CNT_W-1:0]   w_len;
    logic               w_len_bad;
    logic [7:0]         w_xor_next;

    assign w_in_ready = (r_state != S_WRITE);
    assign w_fire     = bus.in_valid && w_in_ready;
    assign w_sync     = (bus.in_data == SYNC_BYTE);
    assign w_len      = {bus.in_data[2:0], r_len_lo};
    assign w_len_bad  = (bus.in_data[7:3] != 5'd0) || (w_len == '0) || (w_len > MAX_N);
    assign w_xor_next = r_xor ^ bus.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_xor        <= 8'd0;
            r_len_lo     <= 8'd0;
            r_lo         <= 8'd0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire && w_sync) begin
                        r_xor   <= 8'd0;
                        r_state <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (w_fire) begin
                        r_len_lo <= bus.in_data;
                        r_xor    <= w_xor_next;
                        r_state  <= S_LEN_H;
                    end
                end
                S_LEN_H: begin
                    if (w_fire) begin
                        r_xor <= w_xor_next;
                        if (w_len_bad) begin
                            r_load_error <= 1'b1;
                            r_state      <= S_ERROR;
                        end else begin
                            r_cnt   <= w_len;
                            r_addr  <= '0;
                            r_state <= S_DAT_L;
                        end
                    end
                end
                S_DAT_L: begin
                    if (w_fire) begin
                        r_lo    <= bus.in_data;
                        r_xor   <= w_xor_next;
                        r_state <= S_DAT_H;
                    end
                end
                S_DAT_H: begin
                    if (w_fire) begin
                        r_xor <= w_xor_next;
                        if (bus.in_data[7:2] != 6'd0) begin
                            r_load_error <= 1'b1;
                            r_state      <= S_ERROR;
                        end else begin
                            // data is staged here so the strobe and its word appear together
                            r_wdata <= {bus.in_data[1:0], r_lo};
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_state <= (r_cnt == CNT_W'(1)) ? S_CHECK : S_DAT_L;
                end
                S_CHECK: begin
                    if (w_fire) begin
                        if (bus.in_data == r_xor) begin
                            r_cpu_hold  <= 1'b0;
                            r_load_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_load_error <= 1'b1;
                            r_state      <= S_ERROR;
                        end
                    end
                end
                S_DONE: begin
                    if (w_fire && w_sync) begin
                        r_cpu_hold  <= 1'b1;
                        r_load_done <= 1'b0;
                        r_xor       <= 8'd0;
                        r_state     <= S_LEN_L;
                    end
                end
                S_ERROR: begin
                    if (w_fire && w_sync) begin
                        r_load_error <= 1'b0;
                        r_xor        <= 8'd0;
                        r_state      <= S_LEN_L;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_done  = r_load_done;
    assign bus.load_error = r_load_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if bus ();

    imem_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rdy_bad = 0;
    logic [9:0] last_addr = 10'd0;
    logic [9:0] mem [0:1023];
    bit stall = 1'b0;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            mem[bus.imem_addr] = bus.imem_wdata;
            last_addr = bus.imem_addr;
            wr_cnt++;
        end
        if (bus.in_ready === bus.imem_we) rdy_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        if (stall) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", 32'(t < 8), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
        chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        chk({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
        chk({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'd1);
        chk({tag, "_load_done"},  32'(bus.load_done),  32'd0);
        chk({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
    endtask

    task automatic basic_frame(input string tag);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h34); send(8'h01);
        send(8'h07); send(8'h02);
        chk({tag, "_hold_before_chk"}, 32'(bus.cpu_hold), 32'd1);
        send(8'h32);
        chk({tag, "_done"}, 32'(bus.load_done), 32'd1);
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
        chk({tag, "_mem0"}, 32'(mem[0]), 32'h134);
        chk({tag, "_mem1"}, 32'(mem[1]), 32'h207);
    endtask

    initial begin
        logic [7:0] x;
        logic [9:0] w;
        int base;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 10'h000;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        // non-SYNC bytes in IDLE are swallowed
        send(8'h00); send(8'h5A);
        chk("idle_ignore_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_ignore_hold", 32'(bus.cpu_hold), 32'd1);

        // basic load with strobe timing checked right after each HI byte
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h34); send(8'h01);
        chk("w0_we", 32'(bus.imem_we), 32'd1);
        chk("w0_addr", 32'(bus.imem_addr), 32'd0);
        chk("w0_data", 32'(bus.imem_wdata), 32'h134);
        send(8'h07); send(8'h02);
        chk("w1_addr", 32'(bus.imem_addr), 32'd1);
        chk("w1_data", 32'(bus.imem_wdata), 32'h207);
        send(8'h32);
        chk("basic_done", 32'(bus.load_done), 32'd1);
        chk("basic_hold", 32'(bus.cpu_hold), 32'd0);
        chk("basic_err", 32'(bus.load_error), 32'd0);
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("basic_mem0", 32'(mem[0]), 32'h134);
        chk("basic_mem1", 32'(mem[1]), 32'h207);

        // reload from DONE, bad checksum
        send(8'hA5);
        chk("reload_hold", 32'(bus.cpu_hold), 32'd1);
        chk("reload_done", 32'(bus.load_done), 32'd0);
        send(8'h02); send(8'h00); send(8'h34); send(8'h01); send(8'h07); send(8'h02);
        send(8'h33);
        chk("badchk_err", 32'(bus.load_error), 32'd1);
        chk("badchk_hold", 32'(bus.cpu_hold), 32'd1);
        chk("badchk_wr_cnt", 32'(wr_cnt), 32'd4);

        // good frame after error, with random stalls
        mem[0] = 10'h000;
        mem[1] = 10'h000;
        stall = 1'b1;
        basic_frame("stall");
        chk("stall_err", 32'(bus.load_error), 32'd0);
        chk("stall_wr_cnt", 32'(wr_cnt), 32'd6);
        stall = 1'b0;

        // single max-value word
        send(8'hA5); send(8'h01); send(8'h00); send(8'hFF); send(8'h03); send(8'hFD);
        chk("maxword_done", 32'(bus.load_done), 32'd1);
        chk("maxword_mem0", 32'(mem[0]), 32'h3FF);

        // bad high byte: no write, error right after
        base = wr_cnt;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h12); send(8'h04);
        chk("badhi_err", 32'(bus.load_error), 32'd1);
        chk("badhi_we", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        chk("badhi_wr_cnt", 32'(wr_cnt), 32'(base));

        // length limits
        send(8'hA5);
        chk("len0_err_clr", 32'(bus.load_error), 32'd0);
        send(8'h00); send(8'h00);
        chk("len0_err", 32'(bus.load_error), 32'd1);
        send(8'hA5); send(8'h01); send(8'h04);
        chk("len401_err", 32'(bus.load_error), 32'd1);
        send(8'hA5); send(8'h01); send(8'h08);
        chk("lenhi_bits_err", 32'(bus.load_error), 32'd1);
        chk("len_wr_cnt", 32'(wr_cnt), 32'(base));

        // full 1024-word frame
        send(8'hA5); send(8'h00); send(8'h04);
        x = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = 10'(i);
            send(w[7:0]);
            send({6'b0, w[9:8]});
            x = x ^ w[7:0] ^ {6'b0, w[9:8]};
        end
        send(x);
        chk("full_done", 32'(bus.load_done), 32'd1);
        chk("full_err", 32'(bus.load_error), 32'd0);
        chk("full_last_addr", 32'(last_addr), 32'h3FF);
        chk("full_wr_cnt", 32'(wr_cnt), 32'(base + 1024));
        chk("full_mem512", 32'(mem[512]), 32'h200);
        chk("full_mem1023", 32'(mem[1023]), 32'h3FF);

        // reset mid-frame after first word of a 3-word frame
        send(8'hA5); send(8'h03); send(8'h00); send(8'h11); send(8'h00);
        send(8'h22);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst_rel");
        basic_frame("after_rst");

        chk("rdy_only_in_write", 32'(rdy_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
